axi_mem_arbiter: RTL and testbench
==================================

Name: axi_mem_arbiter

Overview:
- Two-master, one-slave arbiter for the core's single AXI4-Lite memory port.
- Masters: IFU (read-only: AR/R) and LSU (read: AR/R; write: AW/W/B).
- Exactly one transaction is outstanding on the slave at a time. The grant is held from request until the response handshake completes.
- Sits between the ifu/lsu AXI-Lite master interfaces and the top-level memory/crossbar port.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles from grant before a forced error response. Used only when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ifu_araddr / ifu_arvalid  in  32/1  IFU read address channel
- ifu_arready  out  1  IFU AR accept
- ifu_rdata / ifu_rresp / ifu_rvalid  out  32/2/1  IFU read data channel
- ifu_rready  in  1  IFU R accept
- lsu_araddr / lsu_arvalid  in  32/1  LSU read address channel
- lsu_arready  out  1  LSU AR accept
- lsu_rdata / lsu_rresp / lsu_rvalid  out  32/2/1  LSU read data channel
- lsu_rready  in  1  LSU R accept
- lsu_awaddr / lsu_awvalid / lsu_wdata / lsu_wstrb / lsu_wvalid  in  32/1/32/4/1  LSU write address and data
- lsu_awready / lsu_wready  out  1/1  LSU AW/W accept
- lsu_bresp / lsu_bvalid  out  2/1  LSU write response
- lsu_bready  in  1  LSU B accept
- m_araddr / m_arvalid  out  32/1  slave AR
- m_arready  in  1
- m_rdata / m_rresp / m_rvalid  in  32/2/1  slave R
- m_rready  out  1
- m_awaddr / m_awvalid / m_wdata / m_wstrb / m_wvalid  out  32/1/32/4/1  slave AW/W
- m_awready / m_wready  in  1/1
- m_bresp / m_bvalid  in  2/1  slave B
- m_bready  out  1

Behaviour:
- Reset: state=IDLE, all flags cleared.
  - All valid/ready outputs are 0.
  - All data/resp outputs are 0; they are combinationally gated by the grant.
- States: IDLE, IFU_RD, LSU_RD, LSU_WR.
- Arbitration happens only in IDLE, with fixed priority LSU write (lsu_awvalid|lsu_wvalid) > LSU read (lsu_arvalid) > IFU read (ifu_arvalid).
  - The winner's state is entered on the next edge. No channel is open during the IDLE cycle.
  - With no requests, the block stays in IDLE.
- Routing is combinational from the granted master to m_*. Ungranted master outputs (ready/valid/data) are held at 0.
  - Masters must hold valid and payload stable until handshake.
  - Slave responses, including rresp/bresp 2'b10 and 2'b11, are forwarded unchanged.
- IFU_RD / LSU_RD:
  - m_arvalid = master arvalid & !ar_done.
  - ar_done is set on AR handshake (m_arvalid & m_arready).
  - R is routed through: m_rready = master rready.
  - On R handshake (m_rvalid & m_rready), go to IDLE and clear ar_done.
- LSU_WR:
  - AW and W complete independently; W may precede AW.
  - aw_done and w_done are set on their handshakes and gate m_awvalid and m_wvalid respectively.
  - B is routed through. On B handshake, go to IDLE and clear both flags.
- Each granted transaction produces exactly one handshake per address/data channel. A master re-asserting valid after its handshake is not forwarded.
- Back-pressure: a master holding rready or bready low keeps m_rready or m_bready low. The state is held; no timeout applies unless the feature is enabled.
- Turnaround: at least one IDLE cycle between consecutive grants. Best-case IFU read latency is 1 (arbitration) + 1 (AR) + slave latency.
- A request arriving mid-transaction waits; it is not lost, because the master holds valid.
- Reset mid-transaction: outputs drop to 0 asynchronously and state returns to IDLE. The abandoned slave transaction is the system reset's responsibility.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A $clog2(TIMEOUT_CYCLES)+1-bit counter clears on entering any grant state and increments each cycle while in that state.
  - When it reaches TIMEOUT_CYCLES before the response handshake, the arbiter enters state ERR_RESP. There, m_* valid/ready are 0, and the granted master sees rvalid or bvalid=1 with resp=2'b11 and rdata=0.
  - ERR_RESP is held until the master's ready, then the arbiter returns to IDLE.
  - A response arriving on the same cycle as the timeout wins; no error is generated.
- Undefined: there is no counter and no ERR_RESP state; the arbiter waits indefinitely.

Test Plan:
1. IFU read 0x80000000 alone; slave arready after 2 cycles, rdata=0x00000413, rresp=00 -> ifu_rdata=0x00000413, rresp=00; one AR handshake; back to IDLE; lsu outputs stay 0.
2. ifu_arvalid and lsu_arvalid asserted in the same IDLE cycle -> LSU is granted and ifu_arready stays 0. After the LSU R handshake, one IDLE cycle follows, then the IFU AR is forwarded.
3. LSU write 0x80000010, data 0xdeadbeef, strb 4'b0011, with wvalid 2 cycles before awvalid and m_awready delayed 3 cycles -> exactly one AW and one W handshake with matching payload; bresp=00 delivered; then IDLE.
4. Slave returns rresp=2'b10 to an LSU read while lsu_rready is low for 3 cycles -> m_rready is low for those 3 cycles; lsu_rvalid=1 and lsu_rresp=10 are held stable; the handshake completes on the 4th cycle.
5. Reset asserted mid LSU_WR after the AW handshake -> all outputs are 0 within the same cycle with no clock edge needed; after release, a new IFU read completes normally.
6. With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, the slave never raises rvalid for an IFU read -> 16 cycles after grant, ifu_rvalid=1, rresp=11, rdata=0; IDLE is reached after ifu_rready.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// Two-master (IFU read, LSU read/write) to one AXI4-Lite slave arbiter, one transaction outstanding; optional MEM_ARB_TIMEOUT_EN.
// Latency: one IDLE arbitration cycle, then combinational pass-through of the granted master.
// Backpressure: master/slave ready passed straight through; ungranted master sees ready=0 and waits.
module axi_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_awready,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_awready,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);

    typedef enum logic [2:0] {IDLE, IFU_RD, LSU_RD, LSU_WR, ERR_RESP} state_t;

    state_t state_q, state_d;
    logic   ar_done, aw_done, w_done;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q;
    state_t           err_src;
    logic             tout;

    // Entering ERR_RESP on the edge where the counter would reach TIMEOUT_CYCLES.
    assign tout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            err_src <= IDLE;
        end else begin
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == IFU_RD || state_q == LSU_RD || state_q == LSU_WR)
                cnt_q <= cnt_q + 1'b1;
            if (state_d == ERR_RESP && state_q != ERR_RESP)
                err_src <= state_q;
        end
    end
`else
    logic tout;
    assign tout = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                ar_done <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (m_arvalid && m_arready) ar_done <= 1'b1;
                if (m_awvalid && m_awready) aw_done <= 1'b1;
                if (m_wvalid && m_wready)   w_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lsu_awvalid || lsu_wvalid) state_d = LSU_WR;
                else if (lsu_arvalid)          state_d = LSU_RD;
                else if (ifu_arvalid)          state_d = IFU_RD;
            end
            IFU_RD: begin
                if (m_rvalid && ifu_rready) state_d = IDLE;
                else if (tout)              state_d = ERR_RESP;
            end
            LSU_RD: begin
                if (m_rvalid && lsu_rready) state_d = IDLE;
                else if (tout)              state_d = ERR_RESP;
            end
            LSU_WR: begin
                if (m_bvalid && lsu_bready) state_d = IDLE;
                else if (tout)              state_d = ERR_RESP;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            ERR_RESP: begin
                if ((err_src == IFU_RD && ifu_rready) ||
                    (err_src == LSU_RD && lsu_rready) ||
                    (err_src == LSU_WR && lsu_bready))
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ifu_arready = 1'b0; ifu_rdata = '0; ifu_rresp = '0; ifu_rvalid = 1'b0;
        lsu_arready = 1'b0; lsu_rdata = '0; lsu_rresp = '0; lsu_rvalid = 1'b0;
        lsu_awready = 1'b0; lsu_wready = 1'b0; lsu_bresp = '0; lsu_bvalid = 1'b0;
        m_araddr = '0; m_arvalid = 1'b0; m_rready = 1'b0;
        m_awaddr = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0;
        m_bready = 1'b0;
        case (state_q)
            IFU_RD: begin
                m_araddr    = ifu_araddr;
                m_arvalid   = ifu_arvalid & ~ar_done;
                ifu_arready = m_arready & ~ar_done;
                m_rready    = ifu_rready;
                ifu_rvalid  = m_rvalid;
                ifu_rdata   = m_rdata;
                ifu_rresp   = m_rresp;
            end
            LSU_RD: begin
                m_araddr    = lsu_araddr;
                m_arvalid   = lsu_arvalid & ~ar_done;
                lsu_arready = m_arready & ~ar_done;
                m_rready    = lsu_rready;
                lsu_rvalid  = m_rvalid;
                lsu_rdata   = m_rdata;
                lsu_rresp   = m_rresp;
            end
            LSU_WR: begin
                m_awaddr    = lsu_awaddr;
                m_awvalid   = lsu_awvalid & ~aw_done;
                lsu_awready = m_awready & ~aw_done;
                m_wdata     = lsu_wdata;
                m_wstrb     = lsu_wstrb;
                m_wvalid    = lsu_wvalid & ~w_done;
                lsu_wready  = m_wready & ~w_done;
                m_bready    = lsu_bready;
                lsu_bvalid  = m_bvalid;
                lsu_bresp   = m_bresp;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            ERR_RESP: begin
                if (err_src == IFU_RD) begin
                    ifu_rvalid = 1'b1;
                    ifu_rresp  = 2'b11;
                end else if (err_src == LSU_RD) begin
                    lsu_rvalid = 1'b1;
                    lsu_rresp  = 2'b11;
                end else begin
                    lsu_bvalid = 1'b1;
                    lsu_bresp  = 2'b11;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: routing, priority, split AW/W, back-pressure, async reset, optional timeout.
module tb_axi_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ifu_araddr = '0, lsu_araddr = '0, lsu_awaddr = '0, lsu_wdata = '0, m_rdata = '0;
    logic        ifu_arvalid = 0, ifu_rready = 0, lsu_arvalid = 0, lsu_rready = 0;
    logic        lsu_awvalid = 0, lsu_wvalid = 0, lsu_bready = 0;
    logic [3:0]  lsu_wstrb = '0;
    logic        m_arready = 0, m_rvalid = 0, m_awready = 0, m_wready = 0, m_bvalid = 0;
    logic [1:0]  m_rresp = '0, m_bresp = '0;

    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
    logic [31:0] ifu_rdata, lsu_rdata, m_araddr, m_awaddr, m_wdata;
    logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
    logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [3:0]  m_wstrb;

    axi_mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wvalid(lsu_wvalid), .lsu_awready(lsu_awready), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid), .m_awready(m_awready), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clock = ~clock;

    logic outs_or;
    assign outs_or = |{ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid, lsu_arready, lsu_rdata, lsu_rresp,
                       lsu_rvalid, lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid, m_araddr, m_arvalid,
                       m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready};

    // Slave-side handshake monitor
    int          ar_hs = 0, aw_hs = 0, w_hs = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    always @(posedge clock) begin
        if (m_arvalid && m_arready) ar_hs <= ar_hs + 1;
        if (m_awvalid && m_awready) begin aw_hs <= aw_hs + 1; cap_awaddr <= m_awaddr; end
        if (m_wvalid && m_wready)   begin w_hs <= w_hs + 1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb; end
    end

    int checks = 0, failures = 0;
    int ar0, aw0, w0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(); cyc();
        #1 check("rst_outs", 32'(outs_or), 0);
        reset = 1'b0;
        cyc();

        // 1: lone IFU read
        ar0 = ar_hs;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1;
        #1 check("t1_idle_no_ar", 32'(m_arvalid), 0);
        cyc();
        #1 check("t1_arvalid", 32'(m_arvalid), 1);
        check("t1_araddr", m_araddr, 32'h8000_0000);
        cyc(); cyc();
        m_arready = 1;
        #1 check("t1_arready", 32'(ifu_arready), 1);
        cyc();
        m_arready = 0; ifu_arvalid = 0;
        m_rvalid = 1; m_rdata = 32'h0000_0413; m_rresp = 2'b00; ifu_rready = 1;
        #1 check("t1_ar_done", 32'(m_arvalid), 0);
        check("t1_rvalid", 32'(ifu_rvalid), 1);
        check("t1_rdata", ifu_rdata, 32'h0000_0413);
        check("t1_rresp", 32'(ifu_rresp), 0);
        check("t1_lsu_quiet", {lsu_rdata[31:3], lsu_rvalid, lsu_arready, lsu_bvalid}, 0);
        cyc();
        m_rvalid = 0; ifu_rready = 0;
        #1 check("t1_idle_rready", 32'(m_rready), 0);
        check("t1_ar_count", 32'(ar_hs - ar0), 1);

        // 2: simultaneous IFU/LSU read, LSU wins
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1;
        lsu_araddr = 32'h8000_0020; lsu_arvalid = 1;
        cyc();
        m_arready = 1;
        #1 check("t2_lsu_addr", m_araddr, 32'h8000_0020);
        check("t2_lsu_arready", 32'(lsu_arready), 1);
        check("t2_ifu_arready", 32'(ifu_arready), 0);
        cyc();
        lsu_arvalid = 0; m_arready = 0;
        m_rvalid = 1; m_rdata = 32'h0000_1234; lsu_rready = 1;
        #1 check("t2_lsu_rdata", lsu_rdata, 32'h0000_1234);
        check("t2_ifu_rvalid", 32'(ifu_rvalid), 0);
        cyc();
        m_rvalid = 0; lsu_rready = 0;
        #1 check("t2_turnaround", 32'(m_arvalid), 0);
        cyc();
        #1 check("t2_ifu_fwd", 32'(m_arvalid), 1);
        check("t2_ifu_addr", m_araddr, 32'h8000_0004);
        m_arready = 1;
        cyc();
        ifu_arvalid = 0; m_arready = 0; m_rvalid = 1; ifu_rready = 1;
        cyc();
        m_rvalid = 0; ifu_rready = 0;

        // 3: LSU write, W two cycles ahead of AW, AW accepted late
        aw0 = aw_hs; w0 = w_hs;
        lsu_awaddr = 32'h8000_0010; lsu_wdata = 32'hdead_beef; lsu_wstrb = 4'b0011; lsu_wvalid = 1;
        cyc();
        m_wready = 1;
        #1 check("t3_wvalid", 32'(m_wvalid), 1);
        check("t3_awvalid_lo", 32'(m_awvalid), 0);
        cyc();
        lsu_awvalid = 1;
        #1 check("t3_w_gated", 32'(m_wvalid), 0);
        check("t3_awvalid", 32'(m_awvalid), 1);
        cyc(); cyc(); cyc();
        m_awready = 1;
        #1 check("t3_awready", 32'(lsu_awready), 1);
        cyc();
        lsu_awvalid = 0; lsu_wvalid = 0; m_awready = 0; m_wready = 0;
        m_bvalid = 1; m_bresp = 2'b00; lsu_bready = 1;
        #1 check("t3_bvalid", 32'(lsu_bvalid), 1);
        check("t3_bresp", 32'(lsu_bresp), 0);
        cyc();
        m_bvalid = 0; lsu_bready = 0;
        #1 check("t3_idle", 32'(m_bready), 0);
        check("t3_aw_count", 32'(aw_hs - aw0), 1);
        check("t3_w_count", 32'(w_hs - w0), 1);
        check("t3_awaddr", cap_awaddr, 32'h8000_0010);
        check("t3_wdata", cap_wdata, 32'hdead_beef);
        check("t3_wstrb", 32'(cap_wstrb), 32'h3);

        // 4: SLVERR read with master back-pressure
        lsu_araddr = 32'h8000_0030; lsu_arvalid = 1;
        cyc();
        m_arready = 1;
        cyc();
        lsu_arvalid = 0; m_arready = 0;
        m_rvalid = 1; m_rresp = 2'b10; m_rdata = 32'hcafe_0000; lsu_rready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check("t4_rready_lo", 32'(m_rready), 0);
            check("t4_rvalid_held", 32'(lsu_rvalid), 1);
            check("t4_rresp_held", 32'(lsu_rresp), 32'h2);
            cyc();
        end
        lsu_rready = 1;
        #1 check("t4_rready_hi", 32'(m_rready), 1);
        cyc();
        lsu_rready = 0;
        #1 check("t4_idle_gated", 32'(lsu_rvalid), 0);
        m_rvalid = 0; m_rresp = 2'b00;

        // 5: async reset mid-write after AW handshake
        lsu_awaddr = 32'h8000_0040; lsu_awvalid = 1;
        cyc();
        m_awready = 1;
        cyc();
        lsu_awvalid = 0; m_awready = 0; lsu_wvalid = 1;
        #1 check("t5_wvalid", 32'(m_wvalid), 1);
        #1 reset = 1;
        #1 check("t5_async_rst", 32'(outs_or), 0);
        lsu_wvalid = 0;
        cyc();
        reset = 0;
        ifu_araddr = 32'h8000_0100; ifu_arvalid = 1; m_arready = 1;
        cyc();
        #1 check("t5_post_ar", m_araddr, 32'h8000_0100);
        cyc();
        ifu_arvalid = 0; m_arready = 0;
        m_rvalid = 1; m_rdata = 32'h0000_5555; ifu_rready = 1;
        #1 check("t5_post_rdata", ifu_rdata, 32'h0000_5555);
        cyc();
        m_rvalid = 0; ifu_rready = 0;

`ifdef MEM_ARB_TIMEOUT_EN
        // 6: slave never responds
        ifu_araddr = 32'h8000_0200; ifu_arvalid = 1; m_arready = 1;
        cyc();
        for (int i = 0; i < 15; i++) begin
            if (i == 1) begin ifu_arvalid = 0; m_arready = 0; end
            cyc();
        end
        #1 check("t6_pre_tout", 32'(ifu_rvalid), 0);
        cyc();
        m_rdata = 32'h1111_1111;
        #1 check("t6_err_rvalid", 32'(ifu_rvalid), 1);
        check("t6_err_rresp", 32'(ifu_rresp), 32'h3);
        check("t6_err_rdata", ifu_rdata, 0);
        check("t6_err_m_rready", 32'(m_rready), 0);
        ifu_rready = 1;
        cyc();
        ifu_rready = 0; m_rdata = '0;
        #1 check("t6_idle", 32'(ifu_rvalid), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
